ps2_key_rx: RTL

PS2_KEY_RX -- requirements
Module: ps2_key_rx

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_key_rx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: frame FSM states and the scan codes that steer event assembly.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_state_e;

   localparam logic [7:0] SC_E0 = 8'hE0;
   localparam logic [7:0] SC_F0 = 8'hF0;
   localparam logic [7:0] SC_E1 = 8'hE1;
   localparam logic [7:0] SC_12 = 8'h12;

   // Odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
      return ^{dat, par};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for one raw PS/2 line; idles high.
// Output follows a new level after 2 sync cycles plus FILTER_LEN stable cycles; no backpressure.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic filt_o
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          meta_q, sync_q;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Counter runs only while the synchronized level disagrees with the accepted one.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q != filt_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = sync_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         filt_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         meta_q <= raw_i;
         sync_q <= meta_q;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frames bytes, assembles prefix/pause sequences into one key event.
// Event published one cycle after the final stop bit; the keyboard cannot be stalled.
module ps2_key_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int BIT_TIMEOUT = 24000
) (
   input  logic        clk_sys,
   input  logic        RESET,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [64:0] ps2_key,
   output logic        rx_err
);

   localparam int TW = $clog2(BIT_TIMEOUT + 1);

   logic clk_f, dat_f, fall;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk_i (clk_sys),
      .rst_i (RESET),
      .raw_i (ps2_clk),
      .filt_o(clk_f)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
      .clk_i (clk_sys),
      .rst_i (RESET),
      .raw_i (ps2_data),
      .filt_o(dat_f)
   );

   ps2_state_e    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic          clk_prev_q;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          done_q, done_d;
   logic [63:0]   hist_q, hist_d;
   logic [2:0]    pause_q, pause_d;
   logic [64:0]   key_q, key_d;
   logic          err_q, err_d;
   logic          emit;
   logic [63:0]   hist_sh;

   assign fall    = clk_prev_q & ~clk_f;
   assign hist_sh = {hist_q[55:0], shreg_q};

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      hist_d    = hist_q;
      pause_d   = pause_q;
      key_d     = key_q;
      emit      = 1'b0;
      tmo_d     = (state_q == ST_IDLE || fall) ? '0 : tmo_q + TW'(1);

      unique case (state_q)
         ST_IDLE: begin
            if (fall && !dat_f) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (fall) begin
               shreg_d   = {dat_f, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
         end
         ST_PARITY: begin
            if (fall) begin
               par_d   = dat_f;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (fall) begin
               state_d = ST_IDLE;
               if (dat_f && odd_parity_ok(shreg_q, par_q)) done_d = 1'b1;
               else                                         err_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A good byte is acted on in IDLE, so it never coincides with a timeout below.
      if (done_q) begin
         emit = 1'b1;
         if (pause_q != 3'd0) begin
            pause_d = pause_q - 3'd1;
            emit    = (pause_q == 3'd1);
         end else if (shreg_q == SC_E1) begin
            pause_d = 3'd7;
            emit    = 1'b0;
         end else if (shreg_q == SC_E0 || shreg_q == SC_F0) begin
            emit = 1'b0;
         end else if (shreg_q == SC_12 && hist_q[7:0] == SC_E0) begin
            emit = 1'b0;
         end
         if (emit) begin
            key_d  = {~key_q[64], hist_sh};
            hist_d = '0;
         end else begin
            hist_d = hist_sh;
         end
      end

      if (state_q != ST_IDLE && !fall && tmo_q == TW'(BIT_TIMEOUT - 1)) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
         hist_d  = '0;
         pause_d = '0;
         tmo_d   = '0;
      end
   end

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         par_q      <= 1'b0;
         clk_prev_q <= 1'b1;
         tmo_q      <= '0;
         done_q     <= 1'b0;
         hist_q     <= '0;
         pause_q    <= '0;
         key_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         par_q      <= par_d;
         clk_prev_q <= clk_f;
         tmo_q      <= tmo_d;
         done_q     <= done_d;
         hist_q     <= hist_d;
         pause_q    <= pause_d;
         key_q      <= key_d;
         err_q      <= err_d;
      end
   end

   assign ps2_key = key_q;
   assign rx_err  = err_q;

endmodule
